// File: rtl/oport_wrra_pck_arbiter_if.sv
// Request/grant bundle between the input-port request logic (master) and one
// output-port arbiter (slave).
interface oport_wrra_pck_arbiter_if #(
   parameter int P       = 5,
   parameter int WEIGHTw = 4
);
   localparam int P_1 = P - 1;

   logic [P_1-1:0]         request;
   logic [P_1-1:0]         tail;
   logic [P_1*WEIGHTw-1:0] weight;
   logic                   out_ready;
   logic [P_1-1:0]         grant;
   logic                   flit_we;
   logic                   locked;
   logic [P_1-1:0]         owner;

   modport master (
      output request, tail, weight, out_ready,
      input  grant, flit_we, locked, owner
   );

   modport slave (
      input  request, tail, weight, out_ready,
      output grant, flit_we, locked, owner
   );
endinterface

// File: rtl/oport_wrra_pck_arbiter.sv
// Packet-atomic weighted round-robin arbiter sharing one output port among
// the P-1 input ports that can target it.
module oport_wrra_pck_arbiter #(
   parameter int P       = 5,
   parameter int WEIGHTw = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   oport_wrra_pck_arbiter_if.slave bus
);
   localparam int P_1  = P - 1;
   localparam int IDXW = (P_1 > 1) ? $clog2(P_1) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q, state_d;
   logic [IDXW-1:0]      ptr_q, ptr_d;
   logic [WEIGHTw-1:0]   used_q, used_d;
   logic [P_1-1:0]       owner_q, owner_d;

   logic [P_1-1:0]       grant_c;
   logic [IDXW-1:0]      sel_idx, own_idx, gnt_idx;
   logic                 sel_found;
   logic [IDXW:0]        cand;
   logic [WEIGHTw-1:0]   ptr_w, eff_w;
   logic                 pkt_end;

   // First requester at or after ptr, wrapping modulo P_1.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < P_1; k++) begin
         cand = {1'b0, ptr_q} + (IDXW+1)'(k);
         if (cand >= (IDXW+1)'(P_1))
            cand = cand - (IDXW+1)'(P_1);
         if (!sel_found && bus.request[cand[IDXW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDXW-1:0];
         end
      end
   end

   always_comb begin
      own_idx = '0;
      for (int k = 0; k < P_1; k++)
         if (owner_q[k])
            own_idx = IDXW'(k);
   end

   always_comb begin
      grant_c = '0;
      gnt_idx = (state_q == LOCKED) ? own_idx : sel_idx;
      if (!reset && bus.out_ready) begin
         if (state_q == IDLE) begin
            if (sel_found)
               grant_c[sel_idx] = 1'b1;
         end else if (|(owner_q & bus.request)) begin
            grant_c = owner_q;
         end
      end
   end

   assign pkt_end = (|grant_c) && bus.tail[gnt_idx];
   assign ptr_w   = bus.weight[int'(ptr_q)*WEIGHTw +: WEIGHTw];
   assign eff_w   = (ptr_w == '0) ? WEIGHTw'(1) : ptr_w;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      used_d  = used_q;
      if (|grant_c) begin
         if (state_q == IDLE && !bus.tail[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = grant_c;
         end else if (state_q == LOCKED && bus.tail[gnt_idx]) begin
            state_d = IDLE;
            owner_d = '0;
         end
      end
      // Widened compare keeps weight = 2^WEIGHTw-1 from wrapping.
      if (pkt_end) begin
         if (gnt_idx == ptr_q &&
             ({1'b0, used_q} + (WEIGHTw+1)'(1)) < {1'b0, eff_w}) begin
            used_d = used_q + WEIGHTw'(1);
         end else begin
            ptr_d  = (gnt_idx == IDXW'(P_1-1)) ? '0 : gnt_idx + IDXW'(1);
            used_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         used_q  <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         used_q  <= used_d;
         owner_q <= owner_d;
      end
   end

   assign bus.grant   = grant_c;
   assign bus.flit_we = |grant_c;
   assign bus.locked  = (state_q == LOCKED);
   assign bus.owner   = owner_q;
endmodule
